multicycle_core: RTL and testbench



---
 rtl/multicycle_core_if.sv | 24 ++
 rtl/multicycle_core.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Memory/status bundle between multicycle_core (master) and its memory/monitor (slave).
// Handshake: the core holds mem_req with stable mem_we/mem_addr/mem_wdata until a rising edge with mem_req & mem_ready; mem_ready while mem_req=0 is ignored.
interface multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        retire;
  logic        halt;
  logic [31:0] pc;
  logic [2:0]  dbg_state;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, retire, halt, pc, dbg_state,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, retire, halt, pc, dbg_state,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional feature macro: MULTICYCLE_JAL_EN enables jal/jalr decoding.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_core_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] K_ALU    = 3'd0;
  localparam logic [2:0] K_LOAD   = 3'd1;
  localparam logic [2:0] K_STORE  = 3'd2;
  localparam logic [2:0] K_BRANCH = 3'd3;
  localparam logic [2:0] K_JAL    = 3'd4;
  localparam logic [2:0] K_JALR   = 3'd5;

  localparam logic [31:0] ADDR_MASK = (MEM_AW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << MEM_AW) - 32'd1);

  logic [2:0]  r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_wdata, r_imm, r_alu, r_target;
  logic [4:0]  r_rd;
  logic [2:0]  r_kind;
  logic [3:0]  r_fn;
  logic [31:0] r_regs [32];

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u;
  assign w_opc   = r_ir[6:0];
  assign w_f3    = r_ir[14:12];
  assign w_f7    = r_ir[31:25];
  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'd0};
`ifdef MULTICYCLE_JAL_EN
  logic [31:0] w_imm_j;
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
`endif

  logic        w_legal, w_use_imm, w_zero_a;
  logic [2:0]  w_kind;
  logic [3:0]  w_fn;
  logic [31:0] w_imm;

  // r_fn = {alt, funct3}; alt selects sub/sra and is only honoured where the ISA defines it
  always_comb begin
    w_legal   = 1'b0;
    w_use_imm = 1'b1;
    w_zero_a  = 1'b0;
    w_kind    = K_ALU;
    w_fn      = {1'b0, w_f3};
    w_imm     = w_imm_i;
    case (w_opc)
      7'b0110011: begin
        w_use_imm = 1'b0;
        w_fn      = {w_f7[5], w_f3};
        w_legal   = (w_f7 == 7'd0) || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
      end
      7'b0010011: begin
        w_fn    = {(w_f3 == 3'b101) & w_f7[5], w_f3};
        w_legal = (w_f3 == 3'b001) ? (w_f7 == 7'd0) :
                  (w_f3 == 3'b101) ? (w_f7 == 7'd0 || w_f7 == 7'b0100000) : 1'b1;
      end
      7'b0110111: begin
        w_legal  = 1'b1;
        w_zero_a = 1'b1;
        w_fn     = 4'd0;
        w_imm    = w_imm_u;
      end
      7'b0000011: begin
        w_legal = (w_f3 == 3'b010);
        w_kind  = K_LOAD;
        w_fn    = 4'd0;
      end
      7'b0100011: begin
        w_legal = (w_f3 == 3'b010);
        w_kind  = K_STORE;
        w_fn    = 4'd0;
        w_imm   = w_imm_s;
      end
      7'b1100011: begin
        w_legal   = (w_f3 == 3'b000) || (w_f3 == 3'b001);
        w_kind    = K_BRANCH;
        w_use_imm = 1'b0;
        w_imm     = w_imm_b;
      end
`ifdef MULTICYCLE_JAL_EN
      7'b1101111: begin
        w_legal = 1'b1;
        w_kind  = K_JAL;
        w_imm   = w_imm_j;
      end
      7'b1100111: begin
        w_legal = (w_f3 == 3'b000);
        w_kind  = K_JALR;
        w_fn    = 4'd0;
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  logic [31:0] w_alu, w_sra, w_target;
  logic        w_taken, w_fault;
  assign w_sra = $signed(r_a) >>> r_b[4:0];

  always_comb begin
    case (r_fn[2:0])
      3'b000:  w_alu = r_fn[3] ? (r_a - r_b) : (r_a + r_b);
      3'b001:  w_alu = r_a << r_b[4:0];
      3'b010:  w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
      3'b011:  w_alu = {31'd0, r_a < r_b};
      3'b100:  w_alu = r_a ^ r_b;
      3'b101:  w_alu = r_fn[3] ? w_sra : (r_a >> r_b[4:0]);
      3'b110:  w_alu = r_a | r_b;
      default: w_alu = r_a & r_b;
    endcase
  end

  // bne is beq with funct3[0] set, so the comparison result is simply inverted
  assign w_taken  = (r_a == r_b) ^ r_fn[0];
  assign w_target = (r_kind == K_JALR) ? ((r_a + r_imm) & ~32'd1) : (r_pc + r_imm);
  assign w_fault  = ((r_kind == K_LOAD || r_kind == K_STORE) && w_alu[1:0] != 2'd0) ||
                    (r_kind == K_BRANCH && w_taken && w_target[1:0] != 2'd0) ||
                    ((r_kind == K_JAL || r_kind == K_JALR) && w_target[1:0] != 2'd0);

  assign bus.mem_req   = !rst && (r_state == S_FETCH || r_state == S_MEM);
  assign bus.mem_we    = (r_state == S_MEM) && (r_kind == K_STORE);
  assign bus.mem_addr  = ((r_state == S_MEM) ? r_alu : r_pc) & ADDR_MASK & ~32'd3;
  assign bus.mem_wdata = r_wdata;
  assign bus.retire    = (r_state == S_EXEC && r_kind == K_BRANCH && !w_fault) ||
                         (r_state == S_MEM && r_kind == K_STORE && bus.mem_ready) ||
                         (r_state == S_WB);
  assign bus.halt      = (r_state == S_HALT);
  assign bus.pc        = r_pc;
  assign bus.dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (r_state == S_WB && r_rd != 5'd0) begin
      r_regs[r_rd] <= r_alu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_wdata  <= 32'd0;
      r_imm    <= 32'd0;
      r_alu    <= 32'd0;
      r_target <= 32'd0;
      r_rd     <= 5'd0;
      r_kind   <= K_ALU;
      r_fn     <= 4'd0;
    end else begin
      case (r_state)
        S_FETCH: if (bus.mem_ready) begin
          r_ir    <= bus.mem_rdata;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_state <= S_HALT;
          end else begin
            r_a     <= w_zero_a ? 32'd0 : r_regs[r_ir[19:15]];
            r_b     <= w_use_imm ? w_imm : r_regs[r_ir[24:20]];
            r_wdata <= r_regs[r_ir[24:20]];
            r_imm   <= w_imm;
            r_rd    <= r_ir[11:7];
            r_kind  <= w_kind;
            r_fn    <= w_fn;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_fault) begin
            r_state <= S_HALT;
          end else begin
            case (r_kind)
              K_BRANCH: begin
                r_pc    <= w_taken ? w_target : r_pc + 32'd4;
                r_state <= S_FETCH;
              end
              K_LOAD, K_STORE: begin
                r_alu   <= w_alu;
                r_state <= S_MEM;
              end
              K_JAL, K_JALR: begin
                r_alu    <= r_pc + 32'd4;
                r_target <= w_target;
                r_state  <= S_WB;
              end
              default: begin
                r_alu   <= w_alu;
                r_state <= S_WB;
              end
            endcase
          end
        end
        S_MEM: if (bus.mem_ready) begin
          if (r_kind == K_STORE) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
          end else begin
            r_alu   <= bus.mem_rdata;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_pc    <= (r_kind == K_JAL || r_kind == K_JALR) ? r_target : r_pc + 32'd4;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: memory responder, ISA-level reference model, scenario tasks.
module tb_multicycle_core;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  multicycle_core_if bus();
  multicycle_core #(.RESET_PC(RST_PC), .MEM_AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] mm  [256];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  // observed traffic
  int          ready_mode = 0;
  int          wait_done  = 0;
  int          cyc        = 0;
  int          unstable   = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_out   = '0;
  logic [31:0] obs_ret_pc [$];
  int          obs_ret_cyc [$];
  logic [63:0] obs_st [$];
  logic [31:0] obs_rd [$];

  // expected traffic from the model
  logic [31:0] exp_ret_pc [$];
  int          exp_ret_cyc [$];
  logic [63:0] exp_q [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_halt_pc;

  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1: bus.mem_ready = ($urandom_range(0, 2) != 0);
        2: if (bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h8 && wait_done < 3) begin
             bus.mem_ready = 1'b0;
             wait_done++;
           end else bus.mem_ready = 1'b1;
        default: bus.mem_ready = 1'b1;
      endcase
      #1;
      if (rst) begin
        cyc = 0;
        prev_stall = 1'b0;
      end else begin
        cyc++;
        if (prev_stall && bus.mem_req && {bus.mem_we, bus.mem_addr, bus.mem_wdata} != prev_out) unstable++;
        prev_stall = bus.mem_req && !bus.mem_ready;
        prev_out   = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
        if (bus.retire) begin
          obs_ret_pc.push_back(bus.pc);
          obs_ret_cyc.push_back(cyc);
        end
        if (bus.mem_req && bus.mem_ready) begin
          if (bus.mem_we) begin
            obs_st.push_back({bus.mem_addr, bus.mem_wdata});
            mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          end else obs_rd.push_back(bus.mem_addr);
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'd0;
      mm[i]  = 32'd0;
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[9:2]] = w;
    mm[addr[9:2]]  = w;
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: if (alt) return sa >>> b[4:0]; else return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Instruction-level interpreter over mm; cycle counts assume a zero-wait memory.
  task automatic model_run();
    logic [31:0] x [32];
    logic [31:0] p, ir, a, b, ii, si, bi, ji, ea, t, res;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          mc;
    bit          stop, wr;
    exp_ret_pc.delete(); exp_ret_cyc.delete(); exp_q.delete(); exp_rd.delete();
    for (int i = 0; i < 32; i++) x[i] = 32'd0;
    p = RST_PC; mc = 0; stop = 0; exp_halt_pc = 32'hFFFF_FFFF;
    for (int n = 0; n < 400 && !stop; n++) begin
      exp_rd.push_back(p);
      ir = mm[p[9:2]];
      opc = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25]; rd = ir[11:7];
      a = x[ir[19:15]]; b = x[ir[24:20]];
      ii = {{20{ir[31]}}, ir[31:20]};
      si = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      bi = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      ji = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      wr = 0; res = 0; t = p + 32'd4; stop = 1;
      case (opc)
        7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          res = alu_ref(f3, f7[5], a, b); wr = 1; stop = 0; mc += 4;
        end
        7'h13: if ((f3 != 3'd1 || f7 == 7'h00) && (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20)) begin
          res = alu_ref(f3, (f3 == 3'd5) && f7[5], a, ii); wr = 1; stop = 0; mc += 4;
        end
        7'h37: begin res = {ir[31:12], 12'd0}; wr = 1; stop = 0; mc += 4; end
        7'h03: if (f3 == 3'd2) begin
          ea = a + ii;
          if (ea[1:0] == 2'd0) begin
            exp_rd.push_back(ea); res = mm[ea[9:2]]; wr = 1; stop = 0; mc += 5;
          end
        end
        7'h23: if (f3 == 3'd2) begin
          ea = a + si;
          if (ea[1:0] == 2'd0) begin
            exp_q.push_back({ea, b}); mm[ea[9:2]] = b; stop = 0; mc += 4;
          end
        end
        7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin
          if ((a == b) ^ f3[0]) t = p + bi;
          if (t[1:0] == 2'd0) begin stop = 0; mc += 3; end
        end
`ifdef MULTICYCLE_JAL_EN
        7'h6f: begin
          t = p + ji; res = p + 32'd4;
          if (t[1:0] == 2'd0) begin wr = 1; stop = 0; mc += 4; end
        end
        7'h67: if (f3 == 3'd0) begin
          t = (a + ii) & ~32'd1; res = p + 32'd4;
          if (t[1:0] == 2'd0) begin wr = 1; stop = 0; mc += 4; end
        end
`endif
        default: ;
      endcase
      if (stop) exp_halt_pc = p;
      else begin
        if (wr && rd != 5'd0) x[rd] = res;
        exp_ret_pc.push_back(p); exp_ret_cyc.push_back(mc);
        p = t;
      end
    end
    if (ji == 32'hDEAD_BEEF) exp_halt_pc = 32'd0;
  endtask

  task automatic run_dut(input int budget, output bit hit);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    obs_ret_pc.delete(); obs_ret_cyc.delete(); obs_st.delete(); obs_rd.delete();
    unstable = 0; wait_done = 0;
    #1 rst = 1'b0;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk); #2;
      if (bus.halt) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL halt_timeout: halt=%0b required=1 within %0d cycles", bus.halt, budget); end
  endtask

  task automatic test_reset();
    bit hit;
    clear_mem(); put(RST_PC, EBREAK);
    ready_mode = 0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got=%0b exp=0", bus.mem_req); end
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL rst_halt: got=%0b exp=0", bus.halt); end
    total++; if (bus.retire !== 1'b0) begin bad++; $display("FAIL rst_retire: got=%0b exp=0", bus.retire); end
    total++; if (bus.pc !== RST_PC) begin bad++; $display("FAIL rst_pc: got=%h exp=%h", bus.pc, RST_PC); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, RST_PC}) begin
      bad++; $display("FAIL first_fetch: req/we/addr got=%0b/%0b/%h exp=1/0/%h", bus.mem_req, bus.mem_we, bus.mem_addr, RST_PC);
    end
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); #2; if (bus.halt) hit = 1; end
    total++; if (!hit || bus.pc !== RST_PC) begin bad++; $display("FAIL ebreak_halt: halt=%0b pc=%h exp=1/%h", bus.halt, bus.pc, RST_PC); end
  endtask

  task automatic test_alu_store();
    bit hit;
    int exp_c [4] = '{4, 8, 12, 16};
    clear_mem();
    put(RST_PC,        enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    put(RST_PC + 4,    enc_i(-32'd3, 5'd0, 3'd0, 5'd2, 7'h13));
    put(RST_PC + 8,    enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    put(RST_PC + 12,   enc_s(32'd0, 5'd3, 5'd0));
    put(RST_PC + 16,   EBREAK);
    model_run();
    ready_mode = 0;
    run_dut(200, hit);
    total++; if (obs_st.size() !== 1 || obs_st[0] !== {32'd0, 32'd2}) begin
      bad++; $display("FAIL alu_store: n=%0d first=%h exp=1/%h", obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 64'd0, {32'd0, 32'd2});
    end
    total++; if (obs_ret_cyc.size() !== 4) begin bad++; $display("FAIL alu_retire_count: got=%0d exp=4", obs_ret_cyc.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (obs_ret_cyc[i] !== exp_c[i]) begin bad++; $display("FAIL alu_retire_cyc[%0d]: got=%0d exp=%0d", i, obs_ret_cyc[i], exp_c[i]); end
    end
    total++; if (bus.pc !== exp_halt_pc) begin bad++; $display("FAIL alu_halt_pc: got=%h exp=%h", bus.pc, exp_halt_pc); end
  endtask

  task automatic test_load_wait();
    bit hit;
    logic [31:0] word;
    word = $urandom();
    clear_mem();
    put(32'h8, word);
    put(RST_PC,      enc_i(32'd8, 5'd0, 3'd2, 5'd4, 7'h03));
    put(RST_PC + 4,  enc_s(32'h380, 5'd4, 5'd0));
    put(RST_PC + 8,  EBREAK);
    ready_mode = 2;
    run_dut(200, hit);
    ready_mode = 0;
    total++; if (unstable !== 0) begin bad++; $display("FAIL lw_wait_stable: changes=%0d exp=0", unstable); end
    total++; if (obs_st.size() !== 1 || obs_st[0] !== {32'h380, word}) begin
      bad++; $display("FAIL lw_wait_data: n=%0d got=%h exp=%h", obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 64'd0, {32'h380, word});
    end
    total++; if (obs_ret_cyc.size() !== 2 || obs_ret_cyc[0] !== 8 || obs_ret_cyc[1] !== 12) begin
      bad++; $display("FAIL lw_wait_cycles: n=%0d first=%0d exp=2/8/12", obs_ret_cyc.size(), (obs_ret_cyc.size() > 0) ? obs_ret_cyc[0] : -1);
    end
    total++; if (obs_rd.size() < 2 || obs_rd[1] !== 32'h8) begin bad++; $display("FAIL lw_wait_addr: n=%0d exp addr 8", obs_rd.size()); end
  endtask

  task automatic test_branch();
    bit hit;
    logic [31:0] exp_f [4] = '{32'h100, 32'h20, 32'h18, 32'h1C};
    clear_mem();
    put(RST_PC, enc_b(-32'd224, 5'd0, 5'd0, 3'd0));
    put(32'h20, enc_b(-32'd8, 5'd0, 5'd0, 3'd0));
    put(32'h18, enc_b(32'd8, 5'd0, 5'd0, 3'd1));
    put(32'h1C, enc_b(32'd6, 5'd0, 5'd0, 3'd0));
    model_run();
    ready_mode = 0;
    run_dut(200, hit);
    total++; if (obs_rd.size() !== 4) begin bad++; $display("FAIL br_fetch_count: got=%0d exp=4", obs_rd.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (obs_rd[i] !== exp_f[i]) begin bad++; $display("FAIL br_fetch[%0d]: got=%h exp=%h", i, obs_rd[i], exp_f[i]); end
    end
    total++; if (obs_ret_cyc.size() !== 3 || obs_ret_cyc[2] !== 9) begin
      bad++; $display("FAIL br_retire: n=%0d exp=3 retiring at 3,6,9", obs_ret_cyc.size());
    end
    total++; if (bus.pc !== 32'h1C || exp_halt_pc !== 32'h1C) begin
      bad++; $display("FAIL br_misaligned_pc: got=%h model=%h exp=%h", bus.pc, exp_halt_pc, 32'h1C);
    end
  endtask

  task automatic test_misaligned_load();
    bit hit;
    int viol;
    clear_mem();
    put(RST_PC, enc_i(32'd6, 5'd0, 3'd2, 5'd1, 7'h03));
    ready_mode = 0;
    run_dut(200, hit);
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      if (bus.mem_req !== 1'b0 || bus.halt !== 1'b1) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL misal_quiet: violations=%0d exp=0", viol); end
    total++; if (obs_ret_pc.size() !== 0) begin bad++; $display("FAIL misal_retire: got=%0d exp=0", obs_ret_pc.size()); end
    total++; if (bus.pc !== RST_PC) begin bad++; $display("FAIL misal_pc: got=%h exp=%h", bus.pc, RST_PC); end
    run_dut(200, hit);
    total++; if (obs_rd.size() !== 1 || obs_rd[0] !== RST_PC) begin
      bad++; $display("FAIL misal_restart: n=%0d exp first fetch %h", obs_rd.size(), RST_PC);
    end
  endtask

  task automatic test_jal();
    bit hit;
    clear_mem();
    put(RST_PC, enc_b(-32'd192, 5'd0, 5'd0, 3'd0));
    put(32'h40, enc_j(32'd16, 5'd1));
    put(32'h50, enc_s(32'h380, 5'd1, 5'd0));
    put(32'h54, EBREAK);
    model_run();
    ready_mode = 0;
    run_dut(200, hit);
`ifdef MULTICYCLE_JAL_EN
    total++; if (obs_st.size() !== 1 || obs_st[0] !== {32'h380, 32'h44}) begin
      bad++; $display("FAIL jal_link: n=%0d got=%h exp=%h", obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 64'd0, {32'h380, 32'h44});
    end
    total++; if (obs_rd.size() < 3 || obs_rd[2] !== 32'h50) begin bad++; $display("FAIL jal_target: n=%0d exp fetch 50", obs_rd.size()); end
    total++; if (obs_ret_cyc.size() !== 3 || obs_ret_cyc[1] !== 7) begin bad++; $display("FAIL jal_cycles: n=%0d exp jal retiring at 7", obs_ret_cyc.size()); end
`else
    total++; if (bus.pc !== 32'h40 || obs_ret_pc.size() !== 1) begin
      bad++; $display("FAIL jal_illegal: pc=%h retires=%0d exp=40/1", bus.pc, obs_ret_pc.size());
    end
    total++; if (obs_st.size() !== 0) begin bad++; $display("FAIL jal_illegal_store: got=%0d exp=0", obs_st.size()); end
`endif
    total++; if (bus.pc !== exp_halt_pc) begin bad++; $display("FAIL jal_model_pc: got=%h exp=%h", bus.pc, exp_halt_pc); end
  endtask

  task automatic test_random(input int mode, input int n);
    bit hit;
    logic [31:0] pa, w, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    int          k;
    clear_mem();
    for (int i = 0; i < 32; i++) put(32'h300 + 32'(4 * i), $urandom());
    pa = RST_PC;
    for (int i = 0; i < n; i++) begin
      k   = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      f3  = 3'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      imm = $urandom();
      if (k <= 3) w = enc_r({1'b0, alt & (f3 == 3'd0 || f3 == 3'd5), 5'd0}, rs2, rs1, f3, rd);
      else if (k <= 6) begin
        if (f3 == 3'd1) imm[11:5] = 7'd0;
        if (f3 == 3'd5) imm[11:5] = alt ? 7'h20 : 7'h00;
        w = enc_i(imm, rs1, f3, rd, 7'h13);
      end
      else if (k == 7) w = {imm[31:12], rd, 7'h37};
      else if (k == 8) w = enc_i(32'h300 + 32'(4 * $urandom_range(0, 31)), 5'd0, 3'd2, rd, 7'h03);
      else w = enc_b(32'd8, rs2, rs1, {2'b00, alt});
      put(pa, w); pa += 4;
    end
    for (int r = 1; r < 8; r++) begin put(pa, enc_s(32'h380 + 32'(4 * r), 5'(r), 5'd0)); pa += 4; end
    put(pa, EBREAK);
    model_run();
    ready_mode = mode;
    run_dut(3000, hit);
    ready_mode = 0;
    total++; if (obs_st.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_store_count: got=%0d exp=%0d", mode, obs_st.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (obs_st[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_store[%0d]: got=%h exp=%h", mode, i, obs_st[i], exp_q[i]); end
    end
    total++; if (obs_rd.size() !== exp_rd.size()) begin bad++; $display("FAIL rnd%0d_read_count: got=%0d exp=%0d", mode, obs_rd.size(), exp_rd.size()); end
    else foreach (exp_rd[i]) begin
      total++; if (obs_rd[i] !== exp_rd[i]) begin bad++; $display("FAIL rnd%0d_read[%0d]: got=%h exp=%h", mode, i, obs_rd[i], exp_rd[i]); end
    end
    total++; if (obs_ret_pc.size() !== exp_ret_pc.size()) begin bad++; $display("FAIL rnd%0d_retire_count: got=%0d exp=%0d", mode, obs_ret_pc.size(), exp_ret_pc.size()); end
    else foreach (exp_ret_pc[i]) begin
      total++; if (obs_ret_pc[i] !== exp_ret_pc[i]) begin bad++; $display("FAIL rnd%0d_retire_pc[%0d]: got=%h exp=%h", mode, i, obs_ret_pc[i], exp_ret_pc[i]); end
      if (mode == 0) begin
        total++; if (obs_ret_cyc[i] !== exp_ret_cyc[i]) begin bad++; $display("FAIL rnd_retire_cyc[%0d]: got=%0d exp=%0d", i, obs_ret_cyc[i], exp_ret_cyc[i]); end
      end
    end
    total++; if (bus.pc !== exp_halt_pc) begin bad++; $display("FAIL rnd%0d_halt_pc: got=%h exp=%h", mode, bus.pc, exp_halt_pc); end
  endtask

  initial begin
    test_reset();
    test_alu_store();
    test_load_wait();
    test_branch();
    test_misaligned_load();
    test_jal();
    test_random(0, 24);
    test_random(1, 24);
    test_random(1, 24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
